// File: rtl/edma_rsp_if.sv
// Emesh request/response handshake bundle for the memory responder.
// Request: access_in/packet_in/wait_out; response: access_out/packet_out/wait_in.
interface edma_rsp_if #(
   parameter int PW = 104
);
   logic          access_in;
   logic [PW-1:0] packet_in;
   logic          wait_out;
   logic          access_out;
   logic [PW-1:0] packet_out;
   logic          wait_in;

   modport slave (
      input  access_in,
      input  packet_in,
      output wait_out,
      output access_out,
      output packet_out,
      input  wait_in
   );

   modport master (
      output access_in,
      output packet_in,
      input  wait_out,
      input  access_out,
      input  packet_out,
      output wait_in
   );
endinterface

// File: rtl/edma_rsp.sv
// Emesh memory responder: writes/reads an internal word RAM, returns read responses.
// Ports: clk, nreset (async low), bus (slave modport), rd_count/wr_count (wrapping).
module edma_rsp #(
   parameter int AW    = 32,
   parameter int PW    = 104,
   parameter int DEPTH = 1024,
   parameter int MAW   = 10
) (
   input  logic        clk,
   input  logic        nreset,
   edma_rsp_if.slave   bus,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);

   logic [AW-1:0]  mem [DEPTH];
   logic [AW-1:0]  ram_q;

   logic           stall;
   logic           accept;
   logic           wr_en;
   logic           rd_en;

   logic           req_wr;
   logic [1:0]     req_dm;
   logic [4:0]     req_ctrl;
   logic [AW-1:0]  req_dst;
   logic [AW-1:0]  req_data;
   logic [AW-1:0]  req_src;
   logic [MAW-1:0] idx;
   logic [3:0]     be;
   logic [AW-1:0]  wdata;

   logic           s1_valid;
   logic [1:0]     s1_dm;
   logic [4:0]     s1_ctrl;
   logic [AW-1:0]  s1_src;
   logic [1:0]     s1_off;
   logic [AW-1:0]  shifted;
   logic [AW-1:0]  rsp_data;

   logic           unused_bits;

   assign req_wr   = bus.packet_in[0];
   assign req_dm   = bus.packet_in[2:1];
   assign req_ctrl = bus.packet_in[7:3];
   assign req_dst  = bus.packet_in[39:8];
   assign req_data = bus.packet_in[71:40];
   assign req_src  = bus.packet_in[103:72];

   // Upper address bits alias onto the RAM.
   assign idx         = req_dst[MAW+1:2];
   assign unused_bits = ^req_dst[AW-1:MAW+2];

   assign stall        = bus.access_out & bus.wait_in;
   assign bus.wait_out = stall;
   assign accept       = bus.access_in & ~stall;
   // No write may land while reset is held.
   assign wr_en        = accept & req_wr & nreset;
   assign rd_en        = accept & ~req_wr;

   // Lane replication lets the byte enables pick the target lane.
   always_comb begin
      be    = 4'b1111;
      wdata = req_data;
      case (req_dm)
         2'd0: begin
            be    = 4'b0001 << req_dst[1:0];
            wdata = {4{req_data[7:0]}};
         end
         2'd1: begin
            be    = req_dst[1] ? 4'b1100 : 4'b0011;
            wdata = {2{req_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = req_data;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
      if (rd_en) ram_q <= mem[idx];
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         s1_valid <= 1'b0;
         s1_dm    <= '0;
         s1_ctrl  <= '0;
         s1_src   <= '0;
         s1_off   <= '0;
      end else if (!stall) begin
         s1_valid <= rd_en;
         if (rd_en) begin
            s1_dm   <= req_dm;
            s1_ctrl <= req_ctrl;
            s1_src  <= req_src;
            s1_off  <= req_dst[1:0];
         end
      end
   end

   assign shifted = ram_q >> {s1_off, 3'b000};

   always_comb begin
      rsp_data = ram_q;
      case (s1_dm)
         2'd0:    rsp_data = {24'h0, shifted[7:0]};
         2'd1:    rsp_data = {16'h0, s1_off[1] ? ram_q[31:16] : ram_q[15:0]};
         default: rsp_data = ram_q;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         bus.access_out <= 1'b0;
         bus.packet_out <= '0;
      end else if (!stall) begin
         bus.access_out <= s1_valid;
         bus.packet_out <= {{AW{1'b0}}, rsp_data, s1_src,
                            s1_ctrl, s1_dm, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (accept) begin
         if (req_wr) wr_count <= wr_count + 16'd1;
         else        rd_count <= rd_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_edma_rsp.sv
// Self-checking bench for edma_rsp: scoreboard of expected response packets.
// Monitor compares each response transfer against the queue head.
module tb_edma_rsp;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic [15:0] rd_count;
   logic [15:0] wr_count;

   int checks = 0;
   int failures = 0;

   logic [103:0] exp_q[$];

   edma_rsp_if #(.PW(104)) bus ();

   edma_rsp dut (
      .clk      (clk),
      .nreset   (nreset),
      .bus      (bus),
      .rd_count (rd_count),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   function automatic logic [103:0] req(bit wr, logic [1:0] dm,
                                        logic [4:0] ctrl, logic [31:0] dst,
                                        logic [31:0] dat, logic [31:0] src);
      return {src, dat, dst, ctrl, dm, wr};
   endfunction

   function automatic logic [103:0] rsp(logic [1:0] dm, logic [4:0] ctrl,
                                        logic [31:0] src, logic [31:0] dat);
      return {32'h0, dat, src, ctrl, dm, 1'b1};
   endfunction

   // Transfer completes at the next posedge when access_out & ~wait_in.
   always @(negedge clk) begin
      if (nreset && bus.access_out && !bus.wait_in) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_rsp got=%h", bus.packet_out);
         end else begin
            logic [103:0] e;
            e = exp_q.pop_front();
            if (bus.packet_out !== e) begin
               failures++;
               $display("FAIL rsp_packet got=%h want=%h", bus.packet_out, e);
            end
         end
      end
   end

   task automatic send(bit wr, logic [1:0] dm, logic [4:0] ctrl,
                       logic [31:0] dst, logic [31:0] dat, logic [31:0] src);
      bit acc = 1'b0;
      bus.access_in = 1'b1;
      bus.packet_in = req(wr, dm, ctrl, dst, dat, src);
      for (int i = 0; i < 50 && !acc; i++) begin
         acc = !bus.wait_out;
         @(posedge clk);
         #1;
      end
      bus.access_in = 1'b0;
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout dst=%h", dst);
      end
   endtask

   task automatic test_reset();
      bus.access_in = 1'b0;
      bus.packet_in = '0;
      bus.wait_in   = 1'b0;
      nreset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.access_out !== 1'b0 || bus.packet_out !== '0 ||
          bus.wait_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs acc=%b pkt=%h wait=%b want 0",
                  bus.access_out, bus.packet_out, bus.wait_out);
      end
      checks++;
      if (rd_count !== 16'h0 || wr_count !== 16'h0) begin
         failures++;
         $display("FAIL reset_counts rd=%h wr=%h want 0", rd_count, wr_count);
      end
      nreset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      send(1, 2'd2, 5'd0, 32'h40, 32'h12345678, 32'h0);
      send(0, 2'd2, 5'd5, 32'h40, 32'h0, 32'h80000100);
      exp_q.push_back(rsp(2'd2, 5'd5, 32'h80000100, 32'h12345678));
      checks++;
      if (bus.access_out !== 1'b0) begin
         failures++;
         $display("FAIL latency_early acc=%b want 0", bus.access_out);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.access_out !== 1'b1 ||
          bus.packet_out !== rsp(2'd2, 5'd5, 32'h80000100, 32'h12345678)) begin
         failures++;
         $display("FAIL latency_two acc=%b pkt=%h want 1/%h", bus.access_out,
                  bus.packet_out, rsp(2'd2, 5'd5, 32'h80000100, 32'h12345678));
      end
      checks++;
      if (wr_count !== 16'd1 || rd_count !== 16'd1) begin
         failures++;
         $display("FAIL basic_counts rd=%0d wr=%0d want 1/1", rd_count, wr_count);
      end
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
   endtask

   task automatic test_bytes();
      send(1, 2'd0, 5'd0, 32'h41, 32'h000000AB, 32'h0);
      send(0, 2'd2, 5'd1, 32'h40, 32'h0, 32'h11);
      exp_q.push_back(rsp(2'd2, 5'd1, 32'h11, 32'h1234AB78));
      send(0, 2'd0, 5'd2, 32'h43, 32'h0, 32'h22);
      exp_q.push_back(rsp(2'd0, 5'd2, 32'h22, 32'h00000012));
      send(0, 2'd1, 5'd3, 32'h42, 32'h0, 32'h33);
      exp_q.push_back(rsp(2'd1, 5'd3, 32'h33, 32'h00001234));
      send(1, 2'd1, 5'd0, 32'h42, 32'h0000BEEF, 32'h0);
      send(0, 2'd2, 5'd0, 32'h40, 32'h0, 32'h44);
      exp_q.push_back(rsp(2'd2, 5'd0, 32'h44, 32'hBEEFAB78));
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL bytes_drain left=%0d want 0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] seen;
      for (int i = 0; i < 4; i++)
         send(1, 2'd2, 5'd0, 32'(4 * i), 32'(i + 1), 32'h0);
      for (int i = 0; i < 4; i++) begin
         send(0, 2'd2, 5'd0, 32'(4 * i), 32'h0, 32'(32'h100 + i));
         exp_q.push_back(rsp(2'd2, 5'd0, 32'(32'h100 + i), 32'(i + 1)));
         seen[i] = bus.access_out;
      end
      for (int i = 4; i < 6; i++) begin
         @(posedge clk);
         #1;
         seen[i] = bus.access_out;
      end
      checks++;
      if (seen !== 6'b011110) begin
         failures++;
         $display("FAIL b2b_pattern got=%b want=011110", seen);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_drain left=%0d want 0", exp_q.size());
      end
   endtask

   task automatic test_stall();
      logic [103:0] pkt;
      logic [15:0]  rc;
      logic [15:0]  wc;
      for (int i = 0; i < 3; i++) begin
         bus.access_in = 1'b1;
         bus.packet_in = req(0, 2'd2, 5'd0, 32'(4 * i), 32'h0, 32'(32'h200 + i));
         @(posedge clk);
         #1;
         exp_q.push_back(rsp(2'd2, 5'd0, 32'(32'h200 + i), 32'(i + 1)));
      end
      bus.packet_in = req(0, 2'd2, 5'd0, 32'hC, 32'h0, 32'h203);
      bus.wait_in   = 1'b1;
      #1;
      checks++;
      if (bus.wait_out !== 1'b1) begin
         failures++;
         $display("FAIL stall_wait_out got=%b want 1", bus.wait_out);
      end
      pkt = bus.packet_out;
      rc  = rd_count;
      wc  = wr_count;
      repeat (3) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.packet_out !== pkt || bus.access_out !== 1'b1 ||
             bus.wait_out !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold pkt=%h acc=%b wait=%b want %h/1/1",
                     bus.packet_out, bus.access_out, bus.wait_out, pkt);
         end
         checks++;
         if (rd_count !== rc || wr_count !== wc) begin
            failures++;
            $display("FAIL stall_counts rd=%0d wr=%0d want %0d/%0d",
                     rd_count, wr_count, rc, wc);
         end
      end
      bus.wait_in = 1'b0;
      @(posedge clk);
      #1;
      bus.access_in = 1'b0;
      exp_q.push_back(rsp(2'd2, 5'd0, 32'h203, 32'd4));
      checks++;
      if (rd_count !== rc + 16'd1) begin
         failures++;
         $display("FAIL stall_accept rd=%0d want %0d", rd_count, rc + 16'd1);
      end
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL stall_drain left=%0d want 0", exp_q.size());
      end
   endtask

   task automatic test_alias();
      send(1, 2'd2, 5'd0, 32'h1040, 32'hCAFEF00D, 32'h0);
      send(0, 2'd2, 5'd7, 32'h40, 32'h0, 32'h300);
      exp_q.push_back(rsp(2'd2, 5'd7, 32'h300, 32'hCAFEF00D));
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL alias_drain left=%0d want 0", exp_q.size());
      end
   endtask

   task automatic test_reset_midop();
      send(0, 2'd2, 5'd0, 32'h40, 32'h0, 32'h400);
      send(0, 2'd2, 5'd0, 32'h0, 32'h0, 32'h401);
      nreset = 1'b0;
      #1;
      checks++;
      if (bus.access_out !== 1'b0 || bus.wait_out !== 1'b0 ||
          rd_count !== 16'h0 || wr_count !== 16'h0) begin
         failures++;
         $display("FAIL midreset acc=%b wait=%b rd=%0d wr=%0d want 0",
                  bus.access_out, bus.wait_out, rd_count, wr_count);
      end
      @(posedge clk);
      #1;
      nreset = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.access_out !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_rsp acc=%b want 0", bus.access_out);
         end
      end
      send(0, 2'd2, 5'd0, 32'h40, 32'h0, 32'h402);
      exp_q.push_back(rsp(2'd2, 5'd0, 32'h402, 32'hCAFEF00D));
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0 || rd_count !== 16'd1) begin
         failures++;
         $display("FAIL retained_read left=%0d rd=%0d want 0/1",
                  exp_q.size(), rd_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bytes();
      test_back_to_back();
      test_stall();
      test_alias();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/edma_rsp.md
# edma_rsp

Emesh memory responder: the slave end of the transactions issued by the DMA datapath in master mode. Accepts emesh write and read-request packets, performs them against an internal synchronous word RAM, and returns read-response packets to the requester's return address. Sits on the mesh side opposite an edma channel; also serves as the DMA test target in block-level benches.

## Interface
- AW, 32, address/data field width (only 32 is supported).
- PW, 104, emesh packet width (2*AW+40).
- DEPTH, 1024, RAM depth in 32-bit words (power of two).
- MAW, 10, log2(DEPTH).
- clk  input  1  main clock.
- nreset  input  1  asynchronous active-low reset.
- access_in  input  1  request packet valid.
- packet_in  input  PW  request packet.
- wait_out  output  1  pushback to requester; request not accepted while high.
- access_out  output  1  response packet valid.
- packet_out  output  PW  response packet.
- wait_in  input  1  pushback from response sink.
- rd_count  output  16  reads serviced (wrapping).
- wr_count  output  16  writes serviced (wrapping).

## Operation
- Packet fields: [0] write, [2:1] datamode, [7:3] ctrlmode, [39:8] dstaddr, [71:40] data, [103:72] srcaddr.
- stall = access_out & wait_in; wait_out = stall (combinational). Request accepted at an edge where access_in & ~stall.
- Word index = dstaddr[MAW+1:2]; dstaddr[31:MAW+2] ignored (aliasing).
- datamode 0 byte: lane dstaddr[1:0], writes data[7:0]. 1 halfword: lane dstaddr[1], writes data[15:0]. 2/3 word: writes data[31:0]; dstaddr[1:0] ignored. Other bytes untouched (byte enables).
- Write (write=1): RAM updated at accepting edge; no response; wr_count+1 at same edge.
- Read (write=0): RAM read at accepting edge; header (datamode, ctrlmode, srcaddr, byte offset) captured in stage-1 register; rd_count+1 at same edge.
- Response: write=1, datamode and ctrlmode copied, dstaddr = request srcaddr, srcaddr = 0, data = read word right-aligned and zero-extended per datamode (byte: selected lane in [7:0]; half: selected half in [15:0]; word: full).
- Pipeline: stage 1 (s1_valid + header, RAM output) -> stage 2 (packet_out/access_out). When stall, both stages and RAM output hold; RAM read enable deasserted.
- When ~stall, stage 2 loads from stage 1 each edge; access_out <= s1_valid.
- Read-after-write: write at edge N, read accepted at edge N+1 returns new data.
- Counters wrap from 0xFFFF to 0x0000.

## Timing
- Reset (async, immediate): access_out 0, packet_out 0, s1_valid 0, rd_count 0, wr_count 0; wait_out therefore 0. RAM contents not reset and retained.
- Read accepted at edge N -> access_out high after edge N+1 (latency 2), given no stall.
- Throughput: one request per cycle, back-to-back reads produce back-to-back responses.
- Stall: packet_out and access_out stable while wait_in high; transfer completes at first edge with wait_in low.
- wait_in high while access_out low: no stall; pending response still advances to stage 2 and then holds.
- Interleaved writes do not create response bubbles beyond their own slot (access_out low for that slot).
- Reset mid-operation: in-flight responses discarded; no partial write beyond the edge already taken.

## Test plan
- Word write 0x12345678 to 0x40, then word read of 0x40 with srcaddr 0x80000100, ctrlmode 0x5 -> two edges after read accept: access_out 1, write 1, dstaddr 0x80000100, data 0x12345678, srcaddr 0, ctrlmode 0x5; wr_count 1, rd_count 1.
- Byte write 0xAB to 0x41 after above, word read of 0x40 -> 0x1234AB78; byte read of 0x43 -> 0x00000012; half read of 0x42 -> 0x00001234.
- Four back-to-back reads of 0x0,0x4,0x8,0xC (preloaded 1..4) -> four consecutive access_out cycles with data 1,2,3,4 in order.
- Response pending, wait_in held high 3 cycles while access_in high -> wait_out high, packet_out stable, no accept, counters frozen; release -> queued responses drain one per cycle, no loss or duplication.
- Write to 0x1040 (DEPTH 1024) with 0xCAFEF00D, read 0x40 -> 0xCAFEF00D (aliasing).
- nreset pulsed low with two reads in flight -> access_out 0 immediately, counters 0, no responses after release; subsequent read returns pre-reset RAM contents.
